// File: rtl/sort_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sort_pkg                                                     |
// | Description : Shared types and constants for the insertion-sort output     |
// |               path: framer FSM state encoding, default frame length and    |
// |               shared data width.                                           |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package sort_pkg;

  // Framer control states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,  // waiting for ap_start
    ST_RUN   = 2'b01,  // accepting words from the sort engine
    ST_FLUSH = 2'b10   // all words accepted, draining to the DMA
  } state_t;

  localparam int c_DATA_WIDTH = 32;  // sort engine word width
  localparam int c_FRAME_LEN  = 10;  // words per sorted frame

endpackage : sort_pkg
`default_nettype wire

// File: rtl/sort_sfifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sort_sfifo                                                   |
// | Description : Single-clock first-word-fall-through FIFO. A word written    |
// |               in cycle N appears on rd_data in cycle N+1. Push while full  |
// |               and pop while empty are ignored; a push on a full FIFO is    |
// |               dropped even if a pop happens in the same cycle.             |
// | Ports       : clk, rst (sync, active-high), push/wr_data, pop/rd_data,     |
// |               full, empty                                                  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module sort_sfifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4   // power of 2, >= 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [c_AW:0] c_DEPTH_CNT = (c_AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_wr_ptr;
  logic [c_AW-1:0]  r_rd_ptr;
  logic [c_AW:0]    r_count;

  logic w_push;
  logic w_pop;

  // Full is judged on the registered count only, so a same-cycle pop never
  // frees a slot for the incoming word.
  assign full    = (r_count == c_DEPTH_CNT);
  assign empty   = (r_count == '0);
  assign w_push  = push && !full;
  assign w_pop   = pop && !empty;
  assign rd_data = r_mem[r_rd_ptr];

  // Storage is not reset; empty gates any stale contents downstream.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  // Pointers are c_AW bits wide, so they wrap modulo DEPTH naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (c_AW + 1)'(1);
        2'b01:   r_count <= r_count - (c_AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule : sort_sfifo
`default_nettype wire

// File: rtl/sort_out_framer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sort_out_framer                                              |
// | Description : Output stage of the insertion-sort engine. Buffers the       |
// |               sorted stream in a small FIFO, tags the last word of each    |
// |               frame with sm_tlast, forwards it to the DMA stream and       |
// |               pulses ap_done once the last word has left.                  |
// | Config      : ORDER_CHECK_EN - when defined, flags (sticky order_err) any  |
// |               pushed word smaller than its predecessor in the same frame.  |
// |               When undefined, order_err is tied low.                       |
// | Ports       : clk, rst (sync, active-high), ap_start, ap_done, order_err   |
// |               ss_tvalid/ss_tdata/ss_tready  (from sort engine)             |
// |               sm_tvalid/sm_tdata/sm_tlast/sm_tready (to DMA)               |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module sort_out_framer
  import sort_pkg::*;
#(
  parameter int pDATA_WIDTH = c_DATA_WIDTH,
  parameter int pFRAME_LEN  = c_FRAME_LEN,
  parameter int pFIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ap_start,
  input  logic                   ss_tvalid,
  input  logic [pDATA_WIDTH-1:0] ss_tdata,
  output logic                   ss_tready,
  output logic                   sm_tvalid,
  output logic [pDATA_WIDTH-1:0] sm_tdata,
  output logic                   sm_tlast,
  input  logic                   sm_tready,
  output logic                   ap_done,
  output logic                   order_err
);

  // Counter must be able to hold pFRAME_LEN after the final push.
  localparam int              c_CW       = $clog2(pFRAME_LEN + 1);
  localparam logic [c_CW-1:0] c_LAST_IDX = c_CW'(pFRAME_LEN - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_CW-1:0]    r_wcnt;
  logic               r_ap_done;

  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic               w_start;
  logic               w_is_last;
  logic               w_tlast_pop;
  logic [pDATA_WIDTH:0] w_wr_entry;
  logic [pDATA_WIDTH:0] w_head;

  // Upstream ready depends only on registered state, never on sm_tready.
  assign ss_tready   = (r_state == ST_RUN) && !w_full;
  assign w_push      = ss_tvalid && ss_tready;
  assign w_start     = ap_start && (r_state == ST_IDLE);
  assign w_is_last   = (r_wcnt == c_LAST_IDX);
  assign w_wr_entry  = {w_is_last, ss_tdata};

  // Head outputs are forced to zero when empty so stale storage never leaks.
  assign sm_tvalid   = !w_empty;
  assign sm_tdata    = w_empty ? '0 : w_head[pDATA_WIDTH-1:0];
  assign sm_tlast    = !w_empty && w_head[pDATA_WIDTH];
  assign w_pop       = sm_tvalid && sm_tready;
  assign w_tlast_pop = w_pop && sm_tlast;
  assign ap_done     = r_ap_done;

  sort_sfifo #(
    .WIDTH (pDATA_WIDTH + 1),
    .DEPTH (pFIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (w_push),
    .wr_data (w_wr_entry),
    .pop     (w_pop),
    .rd_data (w_head),
    .full    (w_full),
    .empty   (w_empty)
  );

  // ---------------------------------------------------------------- FSM ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (ap_start) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_push && w_is_last) begin
          w_state_nxt = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (w_tlast_pop) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // ------------------------------------------------- word count, ap_done ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wcnt    <= '0;
      r_ap_done <= 1'b0;
    end else begin
      if (w_start) begin
        r_wcnt <= '0;
      end else if (w_push) begin
        r_wcnt <= r_wcnt + c_CW'(1);
      end
      // The tlast word can only leave while flushing, since its push moves
      // the FSM out of RUN before it reaches the FIFO head.
      r_ap_done <= (r_state == ST_FLUSH) && w_tlast_pop;
    end
  end

  // ------------------------------------------------------ order checker ----
`ifdef ORDER_CHECK_EN
  logic [pDATA_WIDTH-1:0] r_prev;
  logic                   r_order_err;

  // The first word of a frame (r_wcnt == 0) has no predecessor to compare.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev      <= '0;
      r_order_err <= 1'b0;
    end else begin
      if (w_start) begin
        r_order_err <= 1'b0;
      end else if (w_push && (r_wcnt != '0) && (ss_tdata < r_prev)) begin
        r_order_err <= 1'b1;
      end
      if (w_push) begin
        r_prev <= ss_tdata;
      end
    end
  end

  assign order_err = r_order_err;
`else
  assign order_err = 1'b0;
`endif

endmodule : sort_out_framer
`default_nettype wire

// File: tb/tb_sort_out_framer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_sort_out_framer                                           |
// | Description : Self-checking bench for sort_out_framer. Inputs change on    |
// |               the falling edge, outputs are sampled 1 ns later. Pushed     |
// |               words form the expected stream (tlast on every 10th word of  |
// |               a frame); popped words are collected and compared.           |
// | Config      : ORDER_CHECK_EN - selects expected order_err behaviour.       |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_sort_out_framer;

  localparam int c_W     = 32;
  localparam int c_LEN   = 10;
  localparam int c_DEPTH = 4;
`ifdef ORDER_CHECK_EN
  localparam bit c_CHK = 1'b1;
`else
  localparam bit c_CHK = 1'b0;
`endif

  logic           clk       = 1'b0;
  logic           rst       = 1'b1;
  logic           ap_start  = 1'b0;
  logic           ss_tvalid = 1'b0;
  logic [c_W-1:0] ss_tdata  = '0;
  logic           sm_tready = 1'b0;
  logic           ss_tready;
  logic           sm_tvalid;
  logic [c_W-1:0] sm_tdata;
  logic           sm_tlast;
  logic           ap_done;
  logic           order_err;

  always #5 clk = ~clk;

  sort_out_framer #(
    .pDATA_WIDTH (c_W),
    .pFRAME_LEN  (c_LEN),
    .pFIFO_DEPTH (c_DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ap_start  (ap_start),
    .ss_tvalid (ss_tvalid),
    .ss_tdata  (ss_tdata),
    .ss_tready (ss_tready),
    .sm_tvalid (sm_tvalid),
    .sm_tdata  (sm_tdata),
    .sm_tlast  (sm_tlast),
    .sm_tready (sm_tready),
    .ap_done   (ap_done),
    .order_err (order_err)
  );

  int checks = 0;
  int errors = 0;

  // Reference stream: expected words in push order, words seen leaving.
  logic [c_W:0] exp_q[$];
  logic [c_W:0] got_q[$];
  int           n_push;
  int           done_cnt;
  int           done_misplaced;
  int           stab_viol;
  logic         prev_tlast_pop;
  logic         prev_hold;
  logic [c_W:0] prev_word;

  // Per-cycle samples.
  logic           s_acc, s_tready, s_tvalid, s_err, s_tlast;
  logic [c_W-1:0] s_tdata;

  task automatic clear_model();
    exp_q.delete();
    got_q.delete();
    n_push         = 0;
    done_cnt       = 0;
    done_misplaced = 0;
    stab_viol      = 0;
    prev_tlast_pop = 1'b0;
    prev_hold      = 1'b0;
    prev_word      = '0;
  endtask

  // One clock cycle: drive inputs, sample outputs, update the reference.
  task automatic cycle(input logic v, input logic [c_W-1:0] d,
                       input logic rdy, input logic st);
    @(negedge clk);
    ap_start  = st;
    ss_tvalid = v;
    ss_tdata  = d;
    sm_tready = rdy;
    if (st) n_push = 0;
    #1;
    s_tready = ss_tready;
    s_tvalid = sm_tvalid;
    s_tdata  = sm_tdata;
    s_tlast  = sm_tlast;
    s_err    = order_err;
    s_acc    = v && ss_tready;
    if (ap_done === 1'b1) begin
      done_cnt++;
      if (!prev_tlast_pop) done_misplaced++;
    end else if (prev_tlast_pop) begin
      done_misplaced++;
    end
    if (prev_hold && (sm_tvalid !== 1'b1 || {sm_tlast, sm_tdata} !== prev_word))
      stab_viol++;
    if (s_acc) begin
      exp_q.push_back({(n_push % c_LEN) == c_LEN - 1, d});
      n_push++;
    end
    if (sm_tvalid === 1'b1 && rdy) got_q.push_back({sm_tlast, sm_tdata});
    prev_tlast_pop = (sm_tvalid === 1'b1) && rdy && (sm_tlast === 1'b1);
    prev_hold      = (sm_tvalid === 1'b1) && !rdy;
    prev_word      = {sm_tlast, sm_tdata};
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; ap_start = 1'b0; ss_tvalid = 1'b0; sm_tready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    clear_model();
  endtask

  // Idle cycles with DMA ready until ap_done appears (bounded).
  task automatic drain_until_done(input int target);
    for (int k = 0; k < 60 && done_cnt < target; k++) cycle(1'b0, '0, 1'b1, 1'b0);
  endtask

  // Compares collected output against words 'base'..'base+9' with tlast on the last.
  task automatic check_frame(input string name, input int base);
    checks++;
    if (got_q.size() !== c_LEN) begin
      errors++;
      $display("FAIL %s_count got %0d expected %0d", name, got_q.size(), c_LEN);
    end
    for (int i = 0; i < c_LEN && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== {(i == c_LEN - 1), 32'(base + i)}) begin
        errors++;
        $display("FAIL %s_word[%0d] got %h expected %h", name, i, got_q[i],
                 {(i == c_LEN - 1), 32'(base + i)});
      end
    end
    checks++;
    if (done_cnt !== 1 || done_misplaced !== 0) begin
      errors++;
      $display("FAIL %s_ap_done got pulses %0d misplaced %0d expected 1 and 0",
               name, done_cnt, done_misplaced);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({ss_tready, sm_tvalid, sm_tlast, ap_done, order_err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b expected 00000",
               {ss_tready, sm_tvalid, sm_tlast, ap_done, order_err});
    end
    checks++;
    if (sm_tdata !== '0) begin
      errors++;
      $display("FAIL reset_tdata got %h expected 0", sm_tdata);
    end
    @(negedge clk);
    rst = 1'b0;
    clear_model();
    cycle(1'b1, 32'h55, 1'b1, 1'b0);
    checks++;
    if (s_tready !== 1'b0) begin
      errors++;
      $display("FAIL idle_tready got %b expected 0", s_tready);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    cycle(1'b0, '0, 1'b1, 1'b1);
    for (int i = 1; i <= c_LEN; i++) begin
      cycle(1'b1, 32'(i), 1'b1, 1'b0);
      checks++;
      if (s_acc !== 1'b1) begin
        errors++;
        $display("FAIL b2b_accept[%0d] got %b expected 1", i, s_acc);
      end
    end
    repeat (3) cycle(1'b0, '0, 1'b1, 1'b0);
    check_frame("b2b", 1);
  endtask

  task automatic test_backpressure();
    int w;
    apply_reset();
    cycle(1'b0, '0, 1'b0, 1'b1);
    w = 1;
    for (int k = 0; k < 6; k++) begin
      cycle(1'b1, 32'(w), 1'b0, 1'b0);
      if (s_acc) w++;
    end
    checks++;
    if (w !== 5 || s_tready !== 1'b0) begin
      errors++;
      $display("FAIL bp_accepted got %0d tready %b expected 4 and 0", w - 1, s_tready);
    end
    checks++;
    if (s_tvalid !== 1'b1 || s_tdata !== 32'd1 || stab_viol !== 0) begin
      errors++;
      $display("FAIL bp_hold got valid %b data %h viol %0d expected 1, 1, 0",
               s_tvalid, s_tdata, stab_viol);
    end
    for (int k = 0; k < 60 && w <= c_LEN; k++) begin
      cycle(1'b1, 32'(w), 1'b1, 1'b0);
      if (s_acc) w++;
    end
    drain_until_done(1);
    check_frame("bp", 1);
  endtask

  task automatic test_full_no_pushthrough();
    int w;
    apply_reset();
    cycle(1'b0, '0, 1'b0, 1'b1);
    for (int i = 1; i <= c_DEPTH; i++) cycle(1'b1, 32'(i), 1'b0, 1'b0);
    cycle(1'b1, 32'd5, 1'b1, 1'b0);
    checks++;
    if (s_acc !== 1'b0 || got_q.size() !== 1) begin
      errors++;
      $display("FAIL full_pop_cycle got push %b pops %0d expected 0 and 1",
               s_acc, got_q.size());
    end
    checks++;
    if (got_q.size() > 0 && got_q[0] !== {1'b0, 32'd1}) begin
      errors++;
      $display("FAIL full_pop_data got %h expected %h", got_q[0], {1'b0, 32'd1});
    end
    cycle(1'b1, 32'd5, 1'b0, 1'b0);
    checks++;
    if (s_acc !== 1'b1) begin
      errors++;
      $display("FAIL full_next_push got %b expected 1", s_acc);
    end
    w = 6;
    for (int k = 0; k < 60 && w <= c_LEN; k++) begin
      cycle(1'b1, 32'(w), 1'b1, 1'b0);
      if (s_acc) w++;
    end
    drain_until_done(1);
    check_frame("full", 1);
  endtask

  task automatic test_random_frames();
    logic [c_W-1:0] val;
    int             w;
    int             n_last;
    apply_reset();
    val = 32'($urandom_range(0, 1000));
    for (int f = 0; f < 3; f++) begin
      cycle(1'b0, '0, 1'($urandom_range(0, 1)), 1'b1);
      w = 0;
      for (int k = 0; k < 400 && w < c_LEN; k++) begin
        cycle(1'($urandom_range(0, 3) != 0), val, 1'($urandom_range(0, 1)), 1'b0);
        if (s_acc) begin
          w++;
          val = val + 32'($urandom_range(0, 5));
        end
      end
      // Random tvalid while flushing must be ignored.
      for (int k = 0; k < 400 && done_cnt < f + 1; k++)
        cycle(1'($urandom_range(0, 1)), 32'($urandom), 1'($urandom_range(0, 1)), 1'b0);
      checks++;
      if (w !== c_LEN || done_cnt !== f + 1) begin
        errors++;
        $display("FAIL rnd_frame%0d got words %0d done %0d expected %0d and %0d",
                 f, w, done_cnt, c_LEN, f + 1);
      end
    end
    checks++;
    if (got_q.size() !== exp_q.size() || exp_q.size() !== 3 * c_LEN) begin
      errors++;
      $display("FAIL rnd_count got %0d pushed %0d expected %0d",
               got_q.size(), exp_q.size(), 3 * c_LEN);
    end
    n_last = 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL rnd_word[%0d] got %h expected %h", i, got_q[i], exp_q[i]);
      end
      if (got_q[i][c_W]) n_last++;
    end
    checks++;
    if (n_last !== 3 || done_misplaced !== 0 || stab_viol !== 0) begin
      errors++;
      $display("FAIL rnd_framing got tlasts %0d misplaced %0d unstable %0d expected 3, 0, 0",
               n_last, done_misplaced, stab_viol);
    end
  endtask

  task automatic test_mid_frame_reset();
    int w;
    apply_reset();
    cycle(1'b0, '0, 1'b1, 1'b1);
    w = 1;
    for (int k = 0; k < 20 && w <= 5; k++) begin
      cycle(1'b1, 32'(w), 1'b1, 1'b0);
      if (s_acc) w++;
    end
    @(negedge clk);
    rst = 1'b1; ss_tvalid = 1'b0; sm_tready = 1'b0;
    #1;
    checks++;
    if (sm_tvalid !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_valid got %b expected 1", sm_tvalid);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (sm_tvalid !== 1'b0 || ss_tready !== 1'b0) begin
      errors++;
      $display("FAIL rst_flush got valid %b tready %b expected 0 and 0", sm_tvalid, ss_tready);
    end
    clear_model();
    cycle(1'b0, '0, 1'b1, 1'b1);
    w = 0;
    for (int k = 0; k < 60 && w < c_LEN; k++) begin
      cycle(1'b1, 32'(100 + w), 1'b1, 1'b0);
      if (s_acc) w++;
    end
    drain_until_done(1);
    check_frame("rst", 100);
  endtask

  task automatic test_order_check();
    logic [c_W-1:0] vals [c_LEN];
    logic           m_err;
    int             idx;
    vals = '{32'd5, 32'd7, 32'd3, 32'd8, 32'd9, 32'd10, 32'd11, 32'd12, 32'd13, 32'd14};
    apply_reset();
    m_err = 1'b0;
    cycle(1'b0, '0, 1'b1, 1'b1);
    idx = 0;
    for (int k = 0; k < 60 && idx < c_LEN; k++) begin
      cycle(1'b1, vals[idx], 1'b1, 1'b0);
      checks++;
      if (s_err !== m_err) begin
        errors++;
        $display("FAIL ord_err_word%0d got %b expected %b", idx, s_err, m_err);
      end
      if (s_acc) begin
        if (c_CHK && idx > 0 && vals[idx] < vals[idx - 1]) m_err = 1'b1;
        idx++;
      end
    end
    for (int k = 0; k < 60 && done_cnt < 1; k++) begin
      cycle(1'b0, '0, 1'b1, 1'b0);
      checks++;
      if (s_err !== m_err) begin
        errors++;
        $display("FAIL ord_err_drain got %b expected %b", s_err, m_err);
      end
    end
    cycle(1'b0, '0, 1'b1, 1'b1);
    checks++;
    if (s_err !== c_CHK) begin
      errors++;
      $display("FAIL ord_err_sticky got %b expected %b", s_err, c_CHK);
    end
    cycle(1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (s_err !== 1'b0) begin
      errors++;
      $display("FAIL ord_err_clear got %b expected 0", s_err);
    end
  endtask

  initial begin
    clear_model();
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_full_no_pushthrough();
    test_random_frames();
    test_mid_frame_reset();
    test_order_check();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_sort_out_framer
`default_nettype wire
